// File: rtl/crono_pkg.sv
// Shared types and BCD limits for the chronometer countdown stage.
package crono_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX         = 4'd5;
    localparam logic [3:0] UNITS_MAX            = 4'd9;
    localparam logic [3:0] HOUR_TENS_MAX        = 4'd2;
    localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;

    // Out-of-range digits are forced to zero when loaded.
    function automatic logic [7:0] fix_ms(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = (v[7:4] > SEC_TENS_MAX) ? 4'd0 : v[7:4];
        u = (v[3:0] > UNITS_MAX) ? 4'd0 : v[3:0];
        return {t, u};
    endfunction

    function automatic logic [7:0] fix_h(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = (v[7:4] > HOUR_TENS_MAX) ? 4'd0 : v[7:4];
        u = v[3:0];
        if (u > UNITS_MAX || (t == HOUR_TENS_MAX && u > HOUR_UNITS_MAX_AT_20))
            u = 4'd0;
        return {t, u};
    endfunction

endpackage

// File: rtl/crono_countdown_bcd_digit_down.sv
// Single BCD digit decrementer with borrow chaining.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = max;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/crono_countdown.sv
// BCD hh:mm:ss countdown with done level and alarm pulse.
// Optional auto-clear of done: define CRONO_ALARM_TIMEOUT_EN.
module crono_countdown
    import crono_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] h_set,
    input  logic [7:0] m_set,
    input  logic [7:0] s_set,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] h_cnt,
    output logic [7:0] m_cnt,
    output logic [7:0] s_cnt,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [23:0]   cnt;
    logic [23:0]   dec;
    logic [6:0]    b;
    logic          cnt_zero;
    logic          dec_zero;
    logic          tick;

    assign h_cnt = cnt[23:16];
    assign m_cnt = cnt[15:8];
    assign s_cnt = cnt[7:0];

    // Borrow ripples through every digit only when the count is 00:00:00.
    assign b[0]     = 1'b1;
    assign cnt_zero = b[6];
    assign dec_zero = (dec == 24'h0);
    assign tick     = (presc == PMAX);

    bcd_digit_down u_s_u (.digit(cnt[3:0]),   .max(UNITS_MAX),
        .borrow_in(b[0]), .digit_next(dec[3:0]),   .borrow_out(b[1]));
    bcd_digit_down u_s_t (.digit(cnt[7:4]),   .max(SEC_TENS_MAX),
        .borrow_in(b[1]), .digit_next(dec[7:4]),   .borrow_out(b[2]));
    bcd_digit_down u_m_u (.digit(cnt[11:8]),  .max(UNITS_MAX),
        .borrow_in(b[2]), .digit_next(dec[11:8]),  .borrow_out(b[3]));
    bcd_digit_down u_m_t (.digit(cnt[15:12]), .max(SEC_TENS_MAX),
        .borrow_in(b[3]), .digit_next(dec[15:12]), .borrow_out(b[4]));
    bcd_digit_down u_h_u (.digit(cnt[19:16]), .max(UNITS_MAX),
        .borrow_in(b[4]), .digit_next(dec[19:16]), .borrow_out(b[5]));
    bcd_digit_down u_h_t (.digit(cnt[23:20]), .max(HOUR_TENS_MAX),
        .borrow_in(b[5]), .digit_next(dec[23:20]), .borrow_out(b[6]));

`ifdef CRONO_ALARM_TIMEOUT_EN
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [AW-1:0] AMAX = AW'(ALARM_SECS - 1);
    logic [AW-1:0] acnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
`ifdef CRONO_ALARM_TIMEOUT_EN
            acnt    <= '0;
`endif
        end else begin
            alarm <= 1'b0;
            if (load && state != RUN) begin
                cnt     <= {fix_h(h_set), fix_ms(m_set), fix_ms(s_set)};
                state   <= IDLE;
                presc   <= '0;
                running <= 1'b0;
                done    <= 1'b0;
`ifdef CRONO_ALARM_TIMEOUT_EN
                acnt    <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE, PAUSE: begin
                        if (!stop && start && !cnt_zero) begin
                            state   <= RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            presc <= '0;
                            if (!cnt_zero) begin
                                cnt <= dec;
                                if (dec_zero) begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                    alarm   <= 1'b1;
                                end
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    DONE: begin
`ifdef CRONO_ALARM_TIMEOUT_EN
                        if (tick) begin
                            presc <= '0;
                            if (acnt == AMAX) begin
                                acnt  <= '0;
                                state <= IDLE;
                                done  <= 1'b0;
                            end else begin
                                acnt <= acnt + 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crono_countdown.sv
// Directed bench for crono_countdown with TICK_DIV=4, ALARM_SECS=3.
// Define CRONO_ALARM_TIMEOUT_EN for both files to cover the timeout build.
module tb_crono_countdown;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] h_set = '0;
    logic [7:0] m_set = '0;
    logic [7:0] s_set = '0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] h_cnt;
    logic [7:0] m_cnt;
    logic [7:0] s_cnt;
    logic       running;
    logic       done;
    logic       alarm;

    int n_checks = 0;
    int n_fails  = 0;

    crono_countdown #(
        .TICK_DIV  (4),
        .ALARM_SECS(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .h_set  (h_set),
        .m_set  (m_set),
        .s_set  (s_set),
        .load   (load),
        .start  (start),
        .stop   (stop),
        .h_cnt  (h_cnt),
        .m_cnt  (m_cnt),
        .s_cnt  (s_cnt),
        .running(running),
        .done   (done),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
        h_set = h;
        m_set = m;
        s_set = s;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    function automatic logic [31:0] cnt();
        return {8'h0, h_cnt, m_cnt, s_cnt};
    endfunction

    initial begin
        #1;
        check("rst_cnt", cnt(), 32'h000000);
        check("rst_flags", {running, done, alarm}, 3'b000);
        step(2);
        reset = 1'b0;

        do_load(8'h00, 8'h01, 8'h00);
        check("load_0100", cnt(), 32'h000100);
        do_start();
        check("run_hi", running, 1'b1);
        step(3);
        check("no_tick_yet", cnt(), 32'h000100);
        step(1);
        check("first_tick", cnt(), 32'h000059);
        step(235);
        check("at_one", cnt(), 32'h000001);
        check("not_done", done, 1'b0);
        step(1);
        check("at_zero", cnt(), 32'h000000);
        check("done_flags", {running, done, alarm}, 3'b011);
        step(1);
        check("alarm_pulse", {done, alarm}, 2'b10);
`ifdef CRONO_ALARM_TIMEOUT_EN
        step(10);
        check("done_11", done, 1'b1);
        step(1);
        check("timeout_clr", done, 1'b0);
        check("timeout_cnt", cnt(), 32'h000000);
        do_start();
        check("zero_no_run", running, 1'b0);
`else
        do_start();
        check("done_ign_start", {running, done}, 2'b01);
        step(100);
        check("done_hold", done, 1'b1);
        check("done_cnt", cnt(), 32'h000000);
`endif

        do_load(8'h10, 8'h00, 8'h00);
        check("load_clr_done", {done, alarm}, 2'b00);
        check("load_100000", cnt(), 32'h100000);
        do_start();
        step(4);
        check("h_borrow_10", cnt(), 32'h095959);

        do_stop();
        check("pause", running, 1'b0);
        do_load(8'h20, 8'h00, 8'h00);
        check("load_200000", cnt(), 32'h200000);
        do_start();
        step(4);
        check("h_borrow_20", cnt(), 32'h195959);
        do_load(8'h05, 8'h00, 8'h00);
        check("load_ign_run", {cnt()[23:0], running}, {24'h195959, 1'b1});

        do_stop();
        do_load(8'h00, 8'h00, 8'h30);
        do_start();
        stop = 1'b1;
        step(20);
        stop = 1'b0;
        check("frozen", cnt(), 32'h000030);
        check("frozen_run", running, 1'b0);
        do_start();
        step(3);
        check("resume_wait", cnt(), 32'h000030);
        step(1);
        check("resume_tick", cnt(), 32'h000029);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("stop_wins", running, 1'b0);
        step(8);
        check("stop_wins_cnt", cnt(), 32'h000029);

        do_load(8'h00, 8'h00, 8'h00);
        do_start();
        check("zero_start", running, 1'b0);
        step(8);
        check("zero_idle", {running, done}, 2'b00);

        do_load(8'h29, 8'h7A, 8'h59);
        check("sanitize", cnt(), 32'h200059);
        do_load(8'h3B, 8'h6F, 8'hC7);
        check("sanitize2", cnt(), 32'h000007);

        do_load(8'h12, 8'h34, 8'h56);
        do_start();
        step(2);
        reset = 1'b1;
        #1;
        check("async_cnt", cnt(), 32'h000000);
        check("async_flags", {running, done, alarm}, 3'b000);
        step(1);
        reset = 1'b0;
        step(1);
        check("post_rst", {running, done, alarm}, 3'b000);
        check("post_rst_cnt", cnt(), 32'h000000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/crono_countdown.md
Name: crono_countdown

Overview:
- Run-time stage directly downstream of the chronometer edit stage.
- Takes the edited BCD hour/minute/second value, loads it on command, and counts down once per second to 00:00:00.
- On reaching zero it raises a done level and a one-cycle alarm pulse.
- Outputs feed the display/RTC-write path in the same BCD format as the edit stage produces.

Parameters:
- TICK_DIV, 100000000, clk cycles per 1 s tick (minimum 2).
- ALARM_SECS, 10, ticks that done stays high when the auto-timeout feature is compiled in.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- h_set  in  8  hours to load, BCD [7:4] tens, [3:0] units, 00-23.
- m_set  in  8  minutes to load, BCD, 00-59.
- s_set  in  8  seconds to load, BCD, 00-59.
- load  in  1  level, sampled per cycle; copy *_set into the counters.
- start  in  1  level, sampled per cycle; begin or resume counting.
- stop  in  1  level, sampled per cycle; pause counting.
- h_cnt  out  8  current hours, BCD.
- m_cnt  out  8  current minutes, BCD.
- s_cnt  out  8  current seconds, BCD.
- running  out  1  high in state RUN.
- done  out  1  high in state DONE.
- alarm  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (asynchronous, immediate):
  - h_cnt=m_cnt=s_cnt=8'h00; running=done=alarm=0.
  - State IDLE; prescaler=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Next cycle the counters hold the *_set values and the state becomes IDLE (DONE clears).
  - Any out-of-range digit is loaded as 0: hour tens >2; hour units >3 when tens=2; hour units >9; minute/second tens >5; units >9.
- start:
  - In IDLE or PAUSE with a nonzero count: RUN next cycle, prescaler cleared to 0.
  - With a zero count: ignored.
- stop: in RUN, go to PAUSE next cycle; counters and prescaler are frozen.
- Priority when inputs coincide in one cycle: load > stop > start.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only.
  - tick is asserted on the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
  - First decrement occurs TICK_DIV cycles after RUN is entered.
- Decrement on tick, BCD borrow chain:
  - s units 0→9 with borrow; s tens 0→5 with borrow.
  - m units and m tens: same rule as seconds.
  - h units 0→9 with borrow; h tens decrements 2→1→0.
  - Never wraps below 00:00:00.
- Terminal condition: the tick that produces 00:00:00 moves the state to DONE in the same update.
  - running=0, done=1, alarm=1 for exactly one cycle.
- DONE holds the counters at zero; start is ignored.
- Counts are monotonic: exactly one decrement per tick, no skipped or double steps.

Optional Feature:
- Macro: CRONO_ALARM_TIMEOUT_EN.
- Defined:
  - In DONE, the prescaler keeps running.
  - After ALARM_SECS ticks, done drops and the state returns to IDLE automatically; counters stay 00:00:00.
  - load still exits DONE early.
- Undefined: done holds until load or reset. ALARM_SECS is unused.

Decomposition:
- Package crono_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - BCD limit constants: SEC_TENS_MAX=5, UNITS_MAX=9, HOUR_TENS_MAX=2, HOUR_UNITS_MAX_AT_20=3.
- Sub-module bcd_digit_down: combinational single-digit decrementer.
  - Inputs: digit, max, borrow_in.
  - Outputs: next digit, borrow_out.
  - Instanced six times in a chain.

Test Plan (TICK_DIV=4, ALARM_SECS=3):
- Reset mid-RUN → all outputs 0, state IDLE within the same cycle, no alarm pulse.
- load 00:01:00, start → after 4 cycles 00:00:59; after 60 ticks 00:00:00; done=1, alarm high for exactly 1 cycle, running=0.
- load 10:00:00, start, 1 tick → 09:59:59; load 20:00:00, 1 tick → 19:59:59.
- RUN at 00:00:30, stop for 20 cycles → count frozen at 00:00:30. start → next decrement exactly 4 cycles later. start+stop together in RUN → PAUSE.
- load 00:00:00, start → stays IDLE, running=0. load h=8'h29, m=8'h7A, s=8'h59 → loads 20:00:59.
- With CRONO_ALARM_TIMEOUT_EN: done high for 12 cycles then IDLE. Without it: done still high after 100 cycles; load clears it.
